// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue controller sequencing register reads, an external ALU and writeback.
module alu_issue_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InstrValid,
  output logic        InstrReady,
  input  logic [15:0] Instr,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic        AluAorL,
  output logic        AluSorU,
  output logic [2:0]  AluOpCode,
  input  logic [31:0] AluResult,
  input  logic        WrEn,
  input  logic [2:0]  WrAddr,
  input  logic [31:0] WrData,
  input  logic [2:0]  RdAddr,
  output logic [31:0] RdData,
  output logic        DoneValid,
  input  logic        DoneReady,
  output logic [2:0]  DoneRd,
  output logic [31:0] DoneData,
  output logic        Busy,
  output logic [15:0] OpCount
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, DONE} state_t;
  state_t state, state_next;
  logic [31:0] regs [8];
  logic [2:0]  op, rd, ra, rb;
  logic        a_or_l, s_or_u, wb_pending, accept, ext_wr;
  logic        unused;
  assign unused = &Instr[1:0];
  always_comb begin
    accept     = state == IDLE && InstrValid;
    ext_wr     = state == IDLE && !InstrValid && WrEn && WrAddr != 3'd0;
    state_next = state == IDLE ? (InstrValid ? READ : IDLE) :
                 state == READ ? EXEC :
                 state == EXEC ? DONE :
                 (DoneReady ? IDLE : DONE);
    InstrReady = state == IDLE;
    Busy       = state != IDLE;
    DoneValid  = state == DONE;
    RdData     = regs[RdAddr];
  end
  always_ff @(posedge Clk)
    state <= Reset ? IDLE : state_next;
  // wb_pending marks the first DONE cycle so writeback and the count happen once per op
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      {op, rd, ra, rb, a_or_l, s_or_u, wb_pending} <= '0;
      {AluA, AluB, AluAorL, AluSorU, AluOpCode} <= '0;
      {DoneData, DoneRd, OpCount} <= '0;
    end else begin
      if (accept) {op, a_or_l, s_or_u, rd, ra, rb} <= Instr[15:2];
      if (state == READ) begin
        AluA      <= regs[ra];
        AluB      <= regs[rb];
        AluOpCode <= op;
        AluAorL   <= a_or_l;
        AluSorU   <= s_or_u;
      end
      if (state == EXEC) begin
        DoneData   <= AluResult;
        DoneRd     <= rd;
        wb_pending <= 1'b1;
      end
      if (state == DONE && wb_pending) begin
        wb_pending <= 1'b0;
        OpCount    <= OpCount + 16'd1;
        if (DoneRd != 3'd0) regs[DoneRd] <= DoneData;
      end
      if (ext_wr) regs[WrAddr] <= WrData;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of issue sequencing, writeback, handshake, wrap and reset.
module tb_alu_issue_ctrl;
  logic        Clk = 1'b0;
  logic        Reset, InstrValid, InstrReady, AluAorL, AluSorU, WrEn, DoneValid, DoneReady, Busy;
  logic [15:0] Instr, OpCount;
  logic [31:0] AluA, AluB, AluResult, WrData, RdData, DoneData;
  logic [2:0]  AluOpCode, WrAddr, RdAddr, DoneRd;
  int checks = 0, errors = 0;
  alu_issue_ctrl dut (
    .Clk(Clk), .Reset(Reset), .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr),
    .AluA(AluA), .AluB(AluB), .AluAorL(AluAorL), .AluSorU(AluSorU), .AluOpCode(AluOpCode),
    .AluResult(AluResult), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdAddr(RdAddr), .RdData(RdData), .DoneValid(DoneValid), .DoneReady(DoneReady),
    .DoneRd(DoneRd), .DoneData(DoneData), .Busy(Busy), .OpCount(OpCount)
  );
  always #10 Clk = ~Clk;
  assign AluResult = AluA + AluB;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    RdAddr = a;
    #1;
    check(tag, RdData, exp);
  endtask
  task automatic preload(input logic [2:0] a, input logic [31:0] d);
    WrEn = 1'b1; WrAddr = a; WrData = d;
    tick;
    WrEn = 1'b0;
  endtask
  function automatic logic [15:0] mk(input logic [2:0] op, input logic al, input logic su,
                                     input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    return {op, al, su, rd, ra, rb, 2'b00};
  endfunction
  task automatic issue(input logic [15:0] ins);
    InstrValid = 1'b1; Instr = ins;
    tick;
    InstrValid = 1'b0;
  endtask
  task automatic run(input logic [15:0] ins);
    issue(ins);
    tick; tick; tick;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    Reset = 1'b1; InstrValid = 1'b0; Instr = '0; WrEn = 1'b0; WrAddr = '0; WrData = '0;
    RdAddr = '0; DoneReady = 1'b0;
    tick; tick;
    Reset = 1'b0;
    check("rst_ready", InstrReady, 1);
    check("rst_busy", Busy, 0);
    check("rst_dv", DoneValid, 0);
    check("rst_cnt", OpCount, 0);
    check("rst_alua", AluA, 0);
    preload(3'd1, 32'd5);
    preload(3'd2, 32'd3);
    rd_check("pre_r1", 3'd1, 32'd5);
    preload(3'd0, 32'h123);
    rd_check("r0_ext_wr", 3'd0, 32'd0);
    // basic add with DONE held for five cycles
    issue(mk(3'b000, 1'b1, 1'b0, 3'd3, 3'd1, 3'd2));
    check("read_busy", Busy, 1);
    check("read_ready", InstrReady, 0);
    check("read_dv", DoneValid, 0);
    tick;
    check("exec_alua", AluA, 32'd5);
    check("exec_alub", AluB, 32'd3);
    check("exec_aorl", AluAorL, 1);
    check("exec_soru", AluSorU, 0);
    check("exec_opc", AluOpCode, 0);
    check("exec_dv", DoneValid, 0);
    tick;
    check("done_dv", DoneValid, 1);
    check("done_data", DoneData, 32'd8);
    check("done_rd", DoneRd, 3'd3);
    check("done_cnt0", OpCount, 0);
    InstrValid = 1'b1; Instr = mk(3'b000, 1'b1, 1'b0, 3'd4, 3'd1, 3'd1);
    WrEn = 1'b1; WrAddr = 3'd2; WrData = 32'hDEAD;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("hold_dv", DoneValid, 1);
      check("hold_data", DoneData, 32'd8);
      check("hold_cnt", OpCount, 1);
      rd_check("hold_r3", 3'd3, 32'd8);
    end
    InstrValid = 1'b0; WrEn = 1'b0; DoneReady = 1'b1;
    tick;
    check("ack_dv", DoneValid, 0);
    check("ack_ready", InstrReady, 1);
    check("ack_cnt", OpCount, 1);
    rd_check("busy_wr_r2", 3'd2, 32'd3);
    rd_check("ignored_r4", 3'd4, 32'd0);
    // back-to-back R1 = R1 + R2
    issue(mk(3'b000, 1'b1, 1'b0, 3'd1, 3'd1, 3'd2));
    check("b2b_rdy1", InstrReady, 0);
    tick;
    check("b2b_rdy2", InstrReady, 0);
    tick;
    check("b2b_rdy3", InstrReady, 0);
    check("b2b_dv1", DoneValid, 1);
    check("b2b_data1", DoneData, 32'd8);
    tick;
    check("b2b_rdy4", InstrReady, 1);
    rd_check("b2b_r1a", 3'd1, 32'd8);
    issue(mk(3'b000, 1'b1, 1'b0, 3'd1, 3'd1, 3'd2));
    tick; tick;
    check("b2b_data2", DoneData, 32'h0000000B);
    tick;
    rd_check("b2b_r1b", 3'd1, 32'h0000000B);
    check("b2b_cnt", OpCount, 3);
    // accept and external write in the same cycle; Ra == Rb
    preload(3'd4, 32'h10);
    WrEn = 1'b1; WrAddr = 3'd4; WrData = 32'h77;
    issue(mk(3'b101, 1'b0, 1'b1, 3'd5, 3'd4, 3'd4));
    WrEn = 1'b0;
    tick;
    check("same_a", AluA, 32'h10);
    check("same_b", AluB, 32'h10);
    check("same_opc", AluOpCode, 3'b101);
    check("same_aorl", AluAorL, 0);
    check("same_soru", AluSorU, 1);
    tick;
    check("same_data", DoneData, 32'h20);
    tick;
    rd_check("drop_r4", 3'd4, 32'h10);
    rd_check("same_r5", 3'd5, 32'h20);
    tick; tick;
    check("keep_alua", AluA, 32'h10);
    check("keep_opc", AluOpCode, 3'b101);
    check("keep_soru", AluSorU, 1);
    check("same_cnt", OpCount, 4);
    // Rd = R0 discards writeback
    preload(3'd6, 32'hFFFFFFFF);
    issue(mk(3'b000, 1'b1, 1'b0, 3'd0, 3'd6, 3'd0));
    tick; tick;
    check("r0_data", DoneData, 32'hFFFFFFFF);
    check("r0_rd", DoneRd, 0);
    tick;
    rd_check("r0_read", 3'd0, 32'd0);
    check("r0_cnt", OpCount, 5);
    // OpCount wrap
    force dut.OpCount = 16'hFFFE;
    tick;
    release dut.OpCount;
    run(mk(3'b000, 1'b1, 1'b0, 3'd7, 3'd1, 3'd2));
    check("wrap_ffff", OpCount, 16'hFFFF);
    rd_check("wrap_r7", 3'd7, 32'h0000000E);
    run(mk(3'b000, 1'b1, 1'b0, 3'd7, 3'd1, 3'd2));
    check("wrap_zero", OpCount, 16'h0000);
    // reset in DONE before handshake, with WrEn asserted
    DoneReady = 1'b0;
    issue(mk(3'b000, 1'b1, 1'b0, 3'd3, 3'd1, 3'd2));
    tick; tick;
    check("pre_rst_dv", DoneValid, 1);
    Reset = 1'b1; WrEn = 1'b1; WrAddr = 3'd2; WrData = 32'd9;
    tick;
    Reset = 1'b0; WrEn = 1'b0;
    check("rstd_dv", DoneValid, 0);
    check("rstd_busy", Busy, 0);
    check("rstd_cnt", OpCount, 0);
    for (int r = 1; r < 8; r++) rd_check("rstd_reg", 3'(r), 32'd0);
    // reset during EXEC
    DoneReady = 1'b1;
    preload(3'd1, 32'd5);
    issue(mk(3'b000, 1'b1, 1'b0, 3'd3, 3'd1, 3'd1));
    tick;
    check("rste_alua_pre", AluA, 32'd5);
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    check("rste_busy", Busy, 0);
    check("rste_ready", InstrReady, 1);
    check("rste_alua", AluA, 0);
    rd_check("rste_r1", 3'd1, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("rste_dv", DoneValid, 0);
      rd_check("rste_r3", 3'd3, 32'd0);
      tick;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
